lmac_reg_rd_arb: RTL

Shares the MAC core's single register-read port (host_addr_reg / reg_rd_start / reg_rd_done_out / FMAC_REGDOUT) between NREQ independent requesters, such as the host config bridge and the statistics poller. It sits between those requesters and the vlmac wrapper and grants them in round-robin order. It sequences one read at a time: issue the address, pulse start, wait for done, return data. A timeout guarantees forward progress if the core never answers.

---
 rtl/lmac_reg_rd_arb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lmac_reg_rd_arb.sv
// lmac_reg_rd_arb: round-robin arbiter that shares the MAC core's single register-read port
// between NREQ requesters. It runs one read at a time: issue the address, pulse the start
// strobe, wait for done (or a timeout), then return the data to the granted requester.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   req_valid/addr    per-requester read requests (address i at req_addr[16i+15:16i])
//   req_ready         one-hot accept, combinational, only in idle
//   rsp_valid/ready   per-requester response handshake (one-hot valid)
//   rsp_data/err      shared response data; err = 1 means timeout and data = ERR_DATA
//   host_addr_reg     address presented to the MAC core
//   reg_rd_start      registered one-cycle read strobe to the MAC core
//   reg_rd_done_out   read-complete pulse from the MAC core
//   FMAC_REGDOUT      read data from the MAC core, valid with done
//   busy              arbiter not idle
//   timeout_cnt       saturating count of timed-out reads
module lmac_reg_rd_arb #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [16*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic [15:0]        host_addr_reg,
  output logic               reg_rd_start,
  input  logic               reg_rd_done_out,
  input  logic [31:0]        FMAC_REGDOUT,
  output logic               busy,
  output logic [15:0]        timeout_cnt
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] gnt;
  logic          gnt_found;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic          start_q, start_d;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    logic [IW:0] idx;
    idx       = '0;
    gnt       = '0;
    gnt_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!gnt_found && req_valid[idx[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt       = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    g_d        = g_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    tcnt_d     = tcnt_q;
    start_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          g_d     = gnt;
          addr_d  = req_addr[16*gnt +: 16];
          start_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        // Done wins over a simultaneous timeout.
        if (reg_rd_done_out) begin
          data_d  = FMAC_REGDOUT;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
          data_d  = ERR_DATA;
          err_d   = 1'b1;
          tcnt_d  = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready[g_q]) begin
          ptr_d   = ({1'b0, g_q} + (IW+1)'(1) == (IW+1)'(NREQ)) ? '0 : g_q + IW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      g_q        <= '0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      g_q        <= g_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
      start_q    <= start_d;
    end
  end

  // req_ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (rst_n && state_q == StIdle && gnt_found) req_ready[gnt] = 1'b1;
    if (state_q == StResp) rsp_valid[g_q] = 1'b1;
  end

  assign rsp_data      = data_q;
  assign rsp_err       = err_q;
  assign host_addr_reg = addr_q;
  assign reg_rd_start  = start_q;
  assign busy          = (state_q != StIdle);
  assign timeout_cnt   = tcnt_q;

endmodule
